// File: rtl/darkbus_pkg.sv
// darkbus_pkg: shared types and constants for the darkbus two-port arbiter.
//   arb_state_t : arbiter FSM states
//   GNT_*       : one-hot grant encodings {D,I}
//   bus_cmd_t   : latched device command (sized for widths up to 32 bits)
package darkbus_pkg;

  localparam int DARKBUS_AW = 32;
  localparam int DARKBUS_DW = 32;
  localparam int DARKBUS_BW = DARKBUS_DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef struct packed {
    logic                  re;
    logic                  we;
    logic [DARKBUS_BW-1:0] be;
    logic [DARKBUS_AW-1:0] addr;
    logic [DARKBUS_DW-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/darkbus_if.sv
// darkbus_if: bundles the fetch (I_*), load/store (D_*), device (M_*) and
// grant signals around the arbiter.
//   modport slave  : arbiter view (serves the core ports, drives the device bus)
//   modport master : environment view (core requesters plus the device)
interface darkbus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            I_REQ;
  logic [AW-1:0]   I_ADDR;
  logic [DW-1:0]   I_RDATA;
  logic            I_ACK;
  logic            I_ERR;

  logic            D_REQ;
  logic            D_WE;
  logic [DW/8-1:0] D_BE;
  logic [AW-1:0]   D_ADDR;
  logic [DW-1:0]   D_WDATA;
  logic [DW-1:0]   D_RDATA;
  logic            D_ACK;
  logic            D_ERR;

  logic            M_EN;
  logic            M_RE;
  logic            M_WE;
  logic [DW/8-1:0] M_BE;
  logic [AW-1:0]   M_ADDR;
  logic [DW-1:0]   M_WDATA;
  logic [DW-1:0]   M_RDATA;
  logic            M_RACK;
  logic            M_WACK;

  logic [1:0]      GNT;

  modport slave (
    input  I_REQ, I_ADDR,
    input  D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    input  M_RDATA, M_RACK, M_WACK,
    output I_RDATA, I_ACK, I_ERR,
    output D_RDATA, D_ACK, D_ERR,
    output M_EN, M_RE, M_WE, M_BE, M_ADDR, M_WDATA,
    output GNT
  );

  modport master (
    output I_REQ, I_ADDR,
    output D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    output M_RDATA, M_RACK, M_WACK,
    input  I_RDATA, I_ACK, I_ERR,
    input  D_RDATA, D_ACK, D_ERR,
    input  M_EN, M_RE, M_WE, M_BE, M_ADDR, M_WDATA,
    input  GNT
  );

endinterface

// File: rtl/darkbus_rr_pick.sv
// darkbus_rr_pick: combinational two-way round-robin picker.
//   req  [1:0] in  : requests {D,I}
//   last       in  : port served last (1 = D, 0 = I)
//   mask [1:0] in  : ports excluded from this pick {D,I}
//   gnt  [1:0] out : one-hot winner {D,I}, 00 when nobody is eligible
module darkbus_rr_pick
  import darkbus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  // On a tie the port that was not served last wins.
  always_comb begin
    eligible = req & ~mask;
    gnt      = GNT_NONE;
    case (eligible)
      2'b01:   gnt = GNT_I;
      2'b10:   gnt = GNT_D;
      2'b11:   gnt = last ? GNT_I : GNT_D;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/darkbus_arbiter.sv
// darkbus_arbiter: round-robin arbiter sharing one device bus between the
// instruction-fetch (I) and load/store (D) ports of the core.
//   XCLK  in : clock
//   XRES  in : asynchronous active-low reset
//   bus      : darkbus_if.slave
//     I_*/D_* : core request ports, one-cycle ACK (+ERR on timeout)
//     M_*     : registered device command, RDATA/RACK/WACK back from device
//     GNT     : current owner {D,I}, 00 when idle
// The command is latched on grant and held until the device acks or the
// wait counter reaches TIMEOUT-1. The command struct limits AW/DW to 32.
module darkbus_arbiter
  import darkbus_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic XCLK,
  input  logic XRES,
  darkbus_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic             last, last_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             own_i, own_d, granted;
  logic             dev_ack, timed_out, done;
  logic [1:0]       mask, pick;

  darkbus_rr_pick u_pick (
    .req  ({bus.D_REQ, bus.I_REQ}),
    .last (last),
    .mask (mask),
    .gnt  (pick)
  );

  // Completion uses the ack matching the latched direction; a device ack
  // in the deadline cycle beats the timeout. The finishing owner is masked
  // so the other port can take the bus without an idle gap.
  always_comb begin
    own_i     = (state == ARB_GNT_I);
    own_d     = (state == ARB_GNT_D);
    granted   = own_i | own_d;
    dev_ack   = granted & (cmd_q.re ? bus.M_RACK : bus.M_WACK);
    timed_out = granted & ~dev_ack & (cnt == CNT_LAST);
    done      = dev_ack | timed_out;
    mask      = GNT_NONE;
    if (done) begin
      mask = own_i ? GNT_I : GNT_D;
    end
  end

  // Next state: re-arbitrate when idle or finishing, otherwise hold the
  // command and count the wait (saturating at the deadline value).
  always_comb begin
    state_d = state;
    cmd_d   = cmd_q;
    last_d  = last;
    cnt_d   = cnt;
    if (!granted || done) begin
      cnt_d = '0;
      case (pick)
        GNT_I: begin
          state_d     = ARB_GNT_I;
          last_d      = 1'b0;
          cmd_d.re    = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.be    = '1;
          cmd_d.addr  = DARKBUS_AW'(bus.I_ADDR);
          cmd_d.wdata = '0;
        end
        GNT_D: begin
          state_d     = ARB_GNT_D;
          last_d      = 1'b1;
          cmd_d.re    = ~bus.D_WE;
          cmd_d.we    = bus.D_WE;
          cmd_d.be    = DARKBUS_BW'(bus.D_BE);
          cmd_d.addr  = DARKBUS_AW'(bus.D_ADDR);
          cmd_d.wdata = DARKBUS_DW'(bus.D_WDATA);
        end
        default: begin
          state_d = ARB_IDLE;
          cmd_d   = '0;
        end
      endcase
    end else if (cnt != CNT_LAST) begin
      cnt_d = cnt + 1'b1;
    end
  end

  // After reset D counts as served last so I wins the first tie.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state <= ARB_IDLE;
      cmd_q <= '0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cmd_q <= cmd_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

  assign bus.GNT     = {own_d, own_i};
  assign bus.M_EN    = granted;
  assign bus.M_RE    = cmd_q.re;
  assign bus.M_WE    = cmd_q.we;
  assign bus.M_BE    = cmd_q.be[DW/8-1:0];
  assign bus.M_ADDR  = cmd_q.addr[AW-1:0];
  assign bus.M_WDATA = cmd_q.wdata[DW-1:0];

  assign bus.I_ACK   = own_i & done;
  assign bus.I_ERR   = own_i & timed_out;
  assign bus.I_RDATA = (own_i & dev_ack) ? bus.M_RDATA : '0;
  assign bus.D_ACK   = own_d & done;
  assign bus.D_ERR   = own_d & timed_out;
  assign bus.D_RDATA = (own_d & dev_ack) ? bus.M_RDATA : '0;

endmodule

// File: tb/tb_darkbus_arbiter.sv
// tb_darkbus_arbiter: directed, table-driven check of darkbus_arbiter with
// TIMEOUT=8. Inputs change 1 time unit after the rising edge and outputs
// are compared 2 units later, well before the next edge.
module tb_darkbus_arbiter;
  import darkbus_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        mrack;
    logic        mwack;
  } stim_t;

  typedef struct {
    logic [1:0]  gnt;
    logic        men;
    logic        mre;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        iack;
    logic        ierr;
    logic [31:0] irdata;
    logic        dack;
    logic        derr;
    logic [31:0] drdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic XCLK = 1'b0;
  logic XRES;
  int   checks = 0;
  int   errors = 0;

  darkbus_if #(.AW(AW), .DW(DW)) bus ();

  darkbus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
    .XCLK (XCLK),
    .XRES (XRES),
    .bus  (bus)
  );

  always #5 XCLK = ~XCLK;

  task automatic apply_stimulus(input stim_t s);
    bus.I_REQ   = s.ireq;
    bus.I_ADDR  = s.iaddr;
    bus.D_REQ   = s.dreq;
    bus.D_WE    = s.dwe;
    bus.D_BE    = s.dbe;
    bus.D_ADDR  = s.daddr;
    bus.D_WDATA = s.dwdata;
    bus.M_RDATA = s.mrdata;
    bus.M_RACK  = s.mrack;
    bus.M_WACK  = s.mwack;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    check_output({tag, " GNT"},     32'(bus.GNT),     32'(e.gnt));
    check_output({tag, " M_EN"},    32'(bus.M_EN),    32'(e.men));
    check_output({tag, " M_RE"},    32'(bus.M_RE),    32'(e.mre));
    check_output({tag, " M_WE"},    32'(bus.M_WE),    32'(e.mwe));
    check_output({tag, " M_BE"},    32'(bus.M_BE),    32'(e.mbe));
    check_output({tag, " M_ADDR"},  bus.M_ADDR,       e.maddr);
    check_output({tag, " M_WDATA"}, bus.M_WDATA,      e.mwdata);
    check_output({tag, " I_ACK"},   32'(bus.I_ACK),   32'(e.iack));
    check_output({tag, " I_ERR"},   32'(bus.I_ERR),   32'(e.ierr));
    check_output({tag, " I_RDATA"}, bus.I_RDATA,      e.irdata);
    check_output({tag, " D_ACK"},   32'(bus.D_ACK),   32'(e.dack));
    check_output({tag, " D_ERR"},   32'(bus.D_ERR),   32'(e.derr));
    check_output({tag, " D_RDATA"}, bus.D_RDATA,      e.drdata);
  endtask

  task automatic next_cycle();
    @(posedge XCLK);
    #1;
  endtask

  stim_t s_zero;
  exp_t  e_idle;
  vec_t  vecs[16];

  initial begin
    s_zero = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    e_idle = '{2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

    // Single fetch: RACK three cycles after the request; RDATA gated outside the ack cycle.
    vecs[0]  = '{'{1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0}, e_idle};
    vecs[1]  = '{'{1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0},
                 '{2'b01, 1, 1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0}};
    vecs[2]  = '{'{1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 32'hDEAD_0000, 0, 0},
                 '{2'b01, 1, 1, 0, 4'hF, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0}};
    vecs[3]  = '{'{1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 32'h13, 1, 0},
                 '{2'b01, 1, 1, 0, 4'hF, 32'h100, 32'h0, 1, 0, 32'h13, 0, 0, 32'h0}};
    vecs[4]  = '{s_zero, e_idle};
    // Write: stray RACK ignored, inputs changed after grant not propagated, WACK completes.
    vecs[5]  = '{'{0, 32'h0, 1, 1, 4'h3, 32'h4000_0004, 32'hCAFE_BABE, 32'h0, 0, 0}, e_idle};
    vecs[6]  = '{'{0, 32'h0, 1, 1, 4'h3, 32'h4000_0004, 32'hCAFE_BABE, 32'h0, 1, 0},
                 '{2'b10, 1, 0, 1, 4'h3, 32'h4000_0004, 32'hCAFE_BABE, 0, 0, 32'h0, 0, 0, 32'h0}};
    vecs[7]  = '{'{0, 32'h0, 1, 0, 4'hF, 32'h9999_0000, 32'h1234_5678, 32'h55, 0, 1},
                 '{2'b10, 1, 0, 1, 4'h3, 32'h4000_0004, 32'hCAFE_BABE, 0, 0, 32'h0, 1, 0, 32'h55}};
    vecs[8]  = '{s_zero, e_idle};
    // Contention: both request, one-cycle acks, grant alternates with no idle gap.
    vecs[9]  = '{'{1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 32'h0, 0, 0}, e_idle};
    vecs[10] = '{'{1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 32'h11, 1, 0},
                 '{2'b01, 1, 1, 0, 4'hF, 32'h200, 32'h0, 1, 0, 32'h11, 0, 0, 32'h0}};
    vecs[11] = '{'{1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 32'h22, 1, 0},
                 '{2'b10, 1, 1, 0, 4'hF, 32'h300, 32'h0, 0, 0, 32'h0, 1, 0, 32'h22}};
    vecs[12] = '{'{1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0, 32'h33, 1, 0},
                 '{2'b01, 1, 1, 0, 4'hF, 32'h200, 32'h0, 1, 0, 32'h33, 0, 0, 32'h0}};
    vecs[13] = '{'{0, 32'h0, 1, 0, 4'hF, 32'h300, 32'h0, 32'h44, 1, 0},
                 '{2'b10, 1, 1, 0, 4'hF, 32'h300, 32'h0, 0, 0, 32'h0, 1, 0, 32'h44}};
    vecs[14] = '{s_zero, e_idle};
    // Acks while idle are ignored.
    vecs[15] = '{'{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h77, 1, 1}, e_idle};

    // Reset state, with a request pending while reset is held.
    XRES = 1'b1;
    apply_stimulus(s_zero);
    #2 XRES = 1'b0;
    bus.I_REQ = 1'b1;
    repeat (2) @(posedge XCLK);
    #1;
    check_exp("reset", e_idle);

    // Simultaneous requests right after reset: I wins the first tie.
    XRES        = 1'b1;
    bus.I_REQ   = 1'b1;
    bus.I_ADDR  = 32'h800;
    bus.D_REQ   = 1'b1;
    bus.D_ADDR  = 32'h700;
    next_cycle();
    check_output("first tie GNT", 32'(bus.GNT), 32'h1);
    check_output("first tie M_ADDR", bus.M_ADDR, 32'h800);

    // Asynchronous reset mid-grant clears the bus without a clock edge.
    #2 XRES = 1'b0;
    #1;
    check_output("async reset GNT", 32'(bus.GNT), 32'h0);
    check_output("async reset M_EN", 32'(bus.M_EN), 32'h0);
    check_output("async reset M_ADDR", bus.M_ADDR, 32'h0);
    check_output("async reset I_ACK", 32'(bus.I_ACK), 32'h0);
    apply_stimulus(s_zero);
    next_cycle();
    XRES = 1'b1;
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].s);
      #2;
      check_exp($sformatf("vec%0d", i), vecs[i].e);
      next_cycle();
    end

    // Timeout: D read never acked; a stray WACK on the deadline cycle is ignored.
    apply_stimulus('{0, 32'h0, 1, 0, 4'hF, 32'h500, 32'h0, 32'h0, 0, 0});
    next_cycle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      bus.M_RDATA = 32'hFFFF_0000 + 32'(k);
      bus.M_WACK  = (k == TIMEOUT);
      #2;
      if (k < TIMEOUT) begin
        check_output($sformatf("timeout wait%0d D_ACK", k), 32'(bus.D_ACK), 32'h0);
        check_output($sformatf("timeout wait%0d GNT", k), 32'(bus.GNT), 32'h2);
      end else begin
        check_output("timeout D_ACK", 32'(bus.D_ACK), 32'h1);
        check_output("timeout D_ERR", 32'(bus.D_ERR), 32'h1);
        check_output("timeout D_RDATA", bus.D_RDATA, 32'h0);
      end
      next_cycle();
    end
    apply_stimulus(s_zero);
    #2;
    check_output("after timeout GNT", 32'(bus.GNT), 32'h0);
    check_output("after timeout M_EN", 32'(bus.M_EN), 32'h0);
    next_cycle();

    // Device ack on the deadline cycle wins over the timeout.
    apply_stimulus('{0, 32'h0, 1, 0, 4'hF, 32'h600, 32'h0, 32'h0, 0, 0});
    next_cycle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      bus.M_RDATA = (k == TIMEOUT) ? 32'hABCD_1234 : 32'h0BAD_0000;
      bus.M_RACK  = (k == TIMEOUT);
      #2;
      if (k == TIMEOUT - 1) begin
        check_output("deadline pre D_ACK", 32'(bus.D_ACK), 32'h0);
        check_output("deadline pre D_RDATA", bus.D_RDATA, 32'h0);
      end else if (k == TIMEOUT) begin
        check_output("deadline D_ACK", 32'(bus.D_ACK), 32'h1);
        check_output("deadline D_ERR", 32'(bus.D_ERR), 32'h0);
        check_output("deadline D_RDATA", bus.D_RDATA, 32'hABCD_1234);
      end
      next_cycle();
    end
    apply_stimulus(s_zero);
    #2;
    check_output("after deadline GNT", 32'(bus.GNT), 32'h0);
    check_output("after deadline M_EN", 32'(bus.M_EN), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
